vec_instr_sequencer: RTL



---
 rtl/vec_instr_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/vec_instr_sequencer.sv
// Instruction sequencer for VECTOR_PROCESSOR: buffers a short program and
// issues it one instruction per clock, stalling on hold and pulsing done.
module vec_instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          hold,
  output logic [IW-1:0] instruct,
  output logic          instr_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic          load_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t        state;
  logic [IW-1:0] mem [DEPTH];
  logic [AW:0]   len;
  logic [AW:0]   count;

  function automatic logic [AW:0] sat_len(input logic [AW:0] p);
    if (p > LEN_MAX) return LEN_MAX;
    return p;
  endfunction

  // Buffer is writable only while idle; a write in the start cycle lands before the first read.
  always_ff @(posedge clk) begin
    if (load_en && state == IDLE) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      instruct    <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pc          <= '0;
      load_err    <= 1'b0;
      len         <= '0;
      count       <= '0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (prog_len == '0) begin
              done <= 1'b1;
            end else begin
              len   <= sat_len(prog_len);
              pc    <= '0;
              count <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (load_en) load_err <= 1'b1;
          // hold freezes the bus and the issue position entirely
          if (!hold) begin
            if (count < len) begin
              instruct    <= mem[pc];
              instr_valid <= 1'b1;
              pc          <= pc + 1'b1;
              count       <= count + 1'b1;
            end else begin
              instruct    <= '0;
              instr_valid <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
